fifo_pkt_writer: RTL

FIFO_PKT_WRITER -- requirements
Module: fifo_pkt_writer

---
 rtl/fifo_pkt_writer_if.sv | 23 ++
 rtl/fifo_pkt_writer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_writer_if.sv
// Upstream stream plus async-FIFO write-port signals of the packet writer.
// The master modport is the writer's view; slave is the environment's view.
interface fifo_pkt_writer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  s_ready;
  logic                  fifo_wr_inc;
  logic [DATA_WIDTH-1:0] fifo_wr_data;
  logic                  fifo_wr_full;

  modport master (
    input  s_valid, s_data, s_last, fifo_wr_full,
    output s_ready, fifo_wr_inc, fifo_wr_data
  );

  modport slave (
    output s_valid, s_data, s_last, fifo_wr_full,
    input  s_ready, fifo_wr_inc, fifo_wr_data
  );
endinterface

// File: rtl/fifo_pkt_writer.sv
// Store-and-forward packet writer: buffers a packet, then writes length header,
// payload and (with FIFO_PKT_WRITER_CHK_EN defined) an XOR trailer to an async FIFO.
module fifo_pkt_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_PKT    = 16
) (
  input  logic                 wr_clk,
  input  logic                 rst_n,
  fifo_pkt_writer_if.master    bus,
  output logic [15:0]          pkt_count,
  output logic                 overflow_err
);

  localparam int CW    = $clog2(MAX_PKT + 1);
  localparam int IW    = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
  localparam int DEPTH = 1 << IW;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HEADER  = 2'd1,
`ifdef FIFO_PKT_WRITER_CHK_EN
    PAYLOAD = 2'd2,
    TRAILER = 2'd3
`else
    PAYLOAD = 2'd2
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         len_q, len_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [15:0]           pkt_q, pkt_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] buf_mem [DEPTH];
  logic [CW-1:0]         cnt_inc;
  logic                  accept;
  logic                  s_ready;
  logic                  wr_inc;
  logic [DATA_WIDTH-1:0] wr_data;
`ifdef FIFO_PKT_WRITER_CHK_EN
  logic [DATA_WIDTH-1:0] chk_q, chk_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    idx_d   = idx_q;
    pkt_d   = pkt_q;
    ovf_d   = ovf_q;
`ifdef FIFO_PKT_WRITER_CHK_EN
    chk_d   = chk_q;
`endif
    s_ready = 1'b0;
    wr_inc  = 1'b0;
    wr_data = '0;
    accept  = 1'b0;
    cnt_inc = cnt_q + CW'(1);

    case (state_q)
      COLLECT: begin
        s_ready = 1'b1;
        accept  = bus.s_valid;
        if (accept) begin
          cnt_d = cnt_inc;
`ifdef FIFO_PKT_WRITER_CHK_EN
          chk_d = (cnt_q == '0) ? bus.s_data : (chk_q ^ bus.s_data);
`endif
          // A full buffer closes the packet even without s_last.
          if (bus.s_last || (cnt_inc == CW'(MAX_PKT))) begin
            len_d   = cnt_inc;
            cnt_d   = '0;
            state_d = HEADER;
            if (!bus.s_last) ovf_d = 1'b1;
          end
        end
      end
      HEADER: begin
        wr_inc  = !bus.fifo_wr_full;
        wr_data = DATA_WIDTH'(len_q);
        if (wr_inc) begin
          state_d = PAYLOAD;
          idx_d   = '0;
        end
      end
      PAYLOAD: begin
        wr_inc  = !bus.fifo_wr_full;
        wr_data = buf_mem[idx_q];
        if (wr_inc) begin
          if (CW'(idx_q) == (len_q - CW'(1))) begin
`ifdef FIFO_PKT_WRITER_CHK_EN
            state_d = TRAILER;
`else
            state_d = COLLECT;
            pkt_d   = pkt_q + 16'd1;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
`ifdef FIFO_PKT_WRITER_CHK_EN
      TRAILER: begin
        wr_inc  = !bus.fifo_wr_full;
        wr_data = chk_q;
        if (wr_inc) begin
          state_d = COLLECT;
          pkt_d   = pkt_q + 16'd1;
        end
      end
`endif
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      pkt_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef FIFO_PKT_WRITER_CHK_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      pkt_q   <= pkt_d;
      ovf_q   <= ovf_d;
`ifdef FIFO_PKT_WRITER_CHK_EN
      chk_q   <= chk_d;
`endif
    end
  end

  // Packet storage needs no reset: only words written this packet are read.
  always_ff @(posedge wr_clk) begin
    if (accept) buf_mem[cnt_q[IW-1:0]] <= bus.s_data;
  end

  assign bus.s_ready      = s_ready;
  assign bus.fifo_wr_inc  = wr_inc;
  assign bus.fifo_wr_data = wr_data;
  assign pkt_count        = pkt_q;
  assign overflow_err     = ovf_q;

endmodule
